// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse-response sequencer: phase encoding and default counter width.
package pulse_seq_pkg;
    localparam int W_CNT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_PULSE = 2'd2,
        S_POST  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with zero flag; holds at zero so a full-scale load never wraps.
module seq_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-response sequencer: repeated pre/pulse/post phases driving bit2pwl and the probe window.
module pulse_seq_ctrl
    import pulse_seq_pkg::*;
#(
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [W_CNT-1:0] pre_cycles,
    input  logic [W_CNT-1:0] pulse_cycles,
    input  logic [W_CNT-1:0] post_cycles,
    input  logic [W_CNT-1:0] n_reps,
    input  logic             pol,
    output logic             bit_out,
    output logic             probe_en,
    output logic [W_CNT-1:0] rep_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    seq_state_t       state_q, state_d;
    logic [W_CNT-1:0] pre_q, pre_d, pulse_q, pulse_d, post_q, post_d, nrep_q, nrep_d;
    logic             pol_q, pol_d;
    logic [W_CNT-1:0] rep_q, rep_d;
    logic             bit_out_q, bit_out_d, probe_en_q, probe_en_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             start_ok, end_rep, phase_done;
    logic             cnt_load, cnt_zero;
    logic [W_CNT-1:0] cnt_val, cnt_unused;

    seq_down_cnt #(.W(W_CNT)) u_phase_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state_q != S_IDLE),
        .cnt      (cnt_unused),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        pulse_d  = pulse_q;
        post_d   = post_q;
        nrep_d   = nrep_q;
        pol_d    = pol_q;
        rep_d    = rep_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        start_ok = 1'b0;
        end_rep  = 1'b0;
        phase_done = cnt_zero && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // abort outranks start, so a simultaneous request neither runs nor errors
                if (start && !abort) begin
                    if ((pulse_cycles == '0) || (n_reps == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        pre_d    = pre_cycles;
                        pulse_d  = pulse_cycles;
                        post_d   = post_cycles;
                        nrep_d   = n_reps;
                        pol_d    = pol;
                        state_d  = (pre_cycles != '0) ? S_PRE : S_PULSE;
                    end
                end
            end
            S_PRE:   if (phase_done) state_d = S_PULSE;
            S_PULSE: if (phase_done) begin
                if (post_q != '0) state_d = S_POST;
                else              end_rep = 1'b1;
            end
            S_POST:  if (phase_done) end_rep = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (end_rep) begin
            if (rep_q < (nrep_q - W_CNT'(1))) begin
                rep_d   = rep_q + W_CNT'(1);
                state_d = (pre_q != '0) ? S_PRE : S_PULSE;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        if (state_d == S_IDLE) rep_d = '0;

        // reload on every phase boundary; PULSE->PULSE (pre=post=0) also reloads here
        cnt_load = start_ok || phase_done;
        case (state_d)
            S_PRE:   cnt_val = pre_d - W_CNT'(1);
            S_PULSE: cnt_val = pulse_d - W_CNT'(1);
            S_POST:  cnt_val = post_d - W_CNT'(1);
            default: cnt_val = '0;
        endcase

        // idle level only follows pol once a run has touched it; otherwise hold
        bit_out_d = bit_out_q;
        if ((state_q != S_IDLE) || (state_d != S_IDLE))
            bit_out_d = (state_d == S_PULSE) ? pol_d : ~pol_d;

        probe_en_d = (state_d == S_PULSE) || (state_d == S_POST);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            pulse_q    <= '0;
            post_q     <= '0;
            nrep_q     <= '0;
            pol_q      <= 1'b0;
            rep_q      <= '0;
            bit_out_q  <= 1'b0;
            probe_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            pulse_q    <= pulse_d;
            post_q     <= post_d;
            nrep_q     <= nrep_d;
            pol_q      <= pol_d;
            rep_q      <= rep_d;
            bit_out_q  <= bit_out_d;
            probe_en_q <= probe_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bit_out  = bit_out_q;
    assign probe_en = probe_en_q;
    assign rep_idx  = rep_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule
